// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink output path.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_e;

  localparam int LED_VAL_W = 4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/led_blink_tx_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable via clear.
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_blink_tx.sv
// Blinks one LED VALUE times (one long blink for zero), then a low gap and a DONE pulse.
module led_blink_tx
  import led_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int ON_TICKS   = 1,
  parameter int OFF_TICKS  = 1,
  parameter int LONG_TICKS = 4,
  parameter int GAP_TICKS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LED_VAL_W-1:0] value,
  output logic                 busy,
  output logic                 done,
  output logic                 led,
  output led_state_e           dbg_state
);

  localparam int MAX_TICKS = max4(ON_TICKS, OFF_TICKS, LONG_TICKS, GAP_TICKS);
  localparam int TCNT_W    = $clog2(MAX_TICKS) + 1;

  led_state_e           state, state_next;
  logic [LED_VAL_W-1:0] rem, rem_next, rem_dec;
  logic [TCNT_W-1:0]    tcnt, tcnt_next, phase_last;
  logic                 done_next;
  logic                 accept;
  logic                 tick;
  logic                 phase_end;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state != IDLE),
    .tick   (tick)
  );

  // In ON, rem is zero only when the latched value was zero, so it selects the long blink.
  always_comb begin
    phase_last = TCNT_W'(ON_TICKS - 1);
    case (state)
      ON:      phase_last = (rem == '0) ? TCNT_W'(LONG_TICKS - 1) : TCNT_W'(ON_TICKS - 1);
      OFF:     phase_last = TCNT_W'(OFF_TICKS - 1);
      GAP:     phase_last = TCNT_W'(GAP_TICKS - 1);
      default: phase_last = TCNT_W'(ON_TICKS - 1);
    endcase
  end

  assign phase_end = tick && (tcnt == phase_last);
  assign rem_dec   = (rem != '0) ? rem - LED_VAL_W'(1) : '0;

  always_comb begin
    state_next = state;
    rem_next   = rem;
    tcnt_next  = tcnt;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          rem_next   = value;
          tcnt_next  = '0;
          state_next = ON;
        end
      end
      ON: begin
        if (phase_end) begin
          rem_next   = rem_dec;
          tcnt_next  = '0;
          state_next = (rem_dec != '0) ? OFF : GAP;
        end else if (tick) begin
          tcnt_next = tcnt + TCNT_W'(1);
        end
      end
      OFF: begin
        if (phase_end) begin
          tcnt_next  = '0;
          state_next = ON;
        end else if (tick) begin
          tcnt_next = tcnt + TCNT_W'(1);
        end
      end
      GAP: begin
        if (phase_end) begin
          tcnt_next  = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (tick) begin
          tcnt_next = tcnt + TCNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      tcnt  <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      tcnt  <= tcnt_next;
      led   <= (state_next == ON);
      busy  <= (state_next != IDLE);
      done  <= done_next;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_led_blink_tx.sv
// Directed bench for led_blink_tx: per-cycle {done,busy,led} traces queued at START and checked each cycle.
module tb_led_blink_tx;
  import led_pkg::*;

  localparam int TD    = 4;
  localparam int ONT   = 2;
  localparam int OFFT  = 2;
  localparam int LONGT = 3;
  localparam int GAPT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] value = 4'd0;
  logic       busy, done, led;
  led_state_e dbg_state;

  logic [2:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int fails = 0;
  int blink_cnt = 0;
  int busy_cnt = 0;
  logic prev_led = 1'b0;

  led_blink_tx #(
    .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .LONG_TICKS(LONGT), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .led(led), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected {done,busy,led} for each cycle after acceptance, built from phase lengths.
  task automatic push_seq(input int v);
    if (v == 0) begin
      repeat (LONGT * TD) exp_q.push_back(3'b011);
    end else begin
      for (int i = 1; i <= v; i++) begin
        repeat (ONT * TD) exp_q.push_back(3'b011);
        if (i < v) repeat (OFFT * TD) exp_q.push_back(3'b010);
      end
    end
    repeat (GAPT * TD) exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
  endtask

  task automatic start_seq(input logic [3:0] v);
    start = 1'b1;
    value = v;
    push_seq(int'(v));
    blink_cnt = 0;
    busy_cnt = 0;
    prev_led = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 4'($urandom_range(0, 15));
  endtask

  task automatic pop_n(input int n);
    logic [2:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("trace_c%0d", i + 1), {29'd0, done, busy, led}, {29'd0, e});
      if (led && !prev_led) blink_cnt++;
      prev_led = led;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic drain();
    pop_n(exp_q.size());
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check(tag, {29'd0, done, busy, led}, 32'd0);
  endtask

  function automatic int busy_expect(input int v);
    if (v == 0) return TD * (LONGT + GAPT);
    return TD * (v * ONT + (v - 1) * OFFT + GAPT);
  endfunction

  initial begin
    int rv;

    repeat (3) @(posedge clk);
    #1;
    check("reset_led", {31'd0, led}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    start_seq(4'd3);
    drain();
    check("v3_blinks", blink_cnt, 3);
    check("v3_busy", busy_cnt, 56);
    idle_check("v3_idle");

    start_seq(4'd0);
    drain();
    check("v0_blinks", blink_cnt, 1);
    check("v0_busy", busy_cnt, 28);
    idle_check("v0_idle");

    start_seq(4'd15);
    drain();
    check("v15_blinks", blink_cnt, 15);
    check("v15_busy", busy_cnt, 248);
    idle_check("v15_idle");

    start_seq(4'd2);
    pop_n(9);
    start = 1'b1;
    value = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("ignored_blinks", blink_cnt, 2);
    check("ignored_busy", busy_cnt, 40);
    idle_check("ignored_idle");

    start_seq(4'd4);
    pop_n(19);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_led", {31'd0, led}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
    exp_q.delete();
    rst_n = 1'b1;
    start_seq(4'd1);
    drain();
    check("post_reset_blinks", blink_cnt, 1);
    check("post_reset_busy", busy_cnt, busy_expect(1));

    start_seq(4'd1);
    drain();
    start_seq(4'd2);
    drain();
    check("b2b_blinks", blink_cnt, 2);
    check("b2b_busy", busy_cnt, busy_expect(2));
    idle_check("b2b_idle");

    for (int n = 0; n < 3; n++) begin
      rv = $urandom_range(1, 7);
      start_seq(4'(rv));
      drain();
      check($sformatf("rand_blinks_v%0d", rv), blink_cnt, rv);
      check($sformatf("rand_busy_v%0d", rv), busy_cnt, busy_expect(rv));
    end
    idle_check("final_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/led_blink_tx.md
# led_blink_tx

Output-side companion to the push-switch debounce/count path: it presents a 4-bit value to the user by blinking one LED that many times. A single-cycle START latches VALUE. The block then drives LED through timed on/off pulses and a closing gap, and signals DONE. It sits between the design's count registers and the board LED pins and runs from the same board clock.

## Interface
- TICK_DIV, default 500000: board clock cycles per timing tick (≥2).
- ON_TICKS, default 1: ticks LED is high per normal blink (≥1).
- OFF_TICKS, default 1: ticks LED is low between blinks (≥1).
- LONG_TICKS, default 4: ticks LED is high for the single blink that represents VALUE=0 (≥1).
- GAP_TICKS, default 4: ticks LED is held low after the last blink, before DONE (≥1).
- CLK  in  1  board clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  request; sampled only while idle.
- VALUE  in  4  value to display; sampled with an accepted START.
- BUSY  out  1  high from the cycle after acceptance until sequence end.
- DONE  out  1  one-cycle pulse at sequence end.
- LED  out  1  LED drive, active-high.

## Operation
- States: IDLE, ON, OFF, GAP.
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE; LED=0, BUSY=0, DONE=0.
  - Prescaler, tick counter and remaining-count register are cleared.
  - Reset mid-sequence aborts immediately, with no DONE.
- IDLE:
  - If START=1, latch VALUE into remaining count, clear prescaler and tick counter, and go to ON.
  - Otherwise hold.
- ON:
  - LED=1.
  - Duration is LONG_TICKS ticks if the latched value is 0, otherwise ON_TICKS ticks.
  - At expiry, decrement remaining count; a latched 0 is not decremented.
  - Then go to OFF if remaining count after decrement >0, else go to GAP.
- OFF: LED=0 for OFF_TICKS ticks, then go to ON.
- GAP: LED=0 for GAP_TICKS ticks, then go to IDLE and assert DONE for that one cycle.
- BUSY=1 exactly when state≠IDLE.
- START while BUSY=1 is ignored; no queuing.
- VALUE changes after acceptance have no effect.
- Back-to-back: START in the DONE cycle (state IDLE) is accepted; LED rises the next cycle.
- Arithmetic and widths:
  - Prescaler counts 0..TICK_DIV-1, width $clog2(TICK_DIV). The tick fires in the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
  - Tick counter width is $clog2(max of the tick parameters)+1. It is cleared on every state change.
  - Remaining count is 4-bit and never wraps below 0.
- Blinks per sequence: VALUE for VALUE≥1 (max 15), and one long blink for VALUE=0.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- START sampled high at edge k (state IDLE) gives LED=1 and BUSY=1 from cycle k+1.
- Each state phase lasts exactly N×TICK_DIV cycles, where N is its tick parameter.
- Total BUSY cycles:
  - VALUE≥1: TICK_DIV×(VALUE×ON_TICKS + (VALUE−1)×OFF_TICKS + GAP_TICKS).
  - VALUE=0: TICK_DIV×(LONG_TICKS+GAP_TICKS).
- DONE is high in the first cycle with BUSY=0; LED=0 in that cycle.

## Structure
- Shared package led_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP), 2-bit;
  - the LED value width constant, 4.
- One sub-module is natural: tick_gen, the prescaler.
  - Ports: CLK, RST_N, clear, enable, tick.
  - Parameter: TICK_DIV.
  - Enabled while BUSY; clear is asserted on acceptance.
- All else lives in led_blink_tx.

## Test plan
Unless stated, TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, LONG_TICKS=3, GAP_TICKS=4; START pulsed at edge k.
- VALUE=3:
  - LED high over cycles k+1..k+8, k+17..k+24 and k+33..k+40; low elsewhere.
  - BUSY high over k+1..k+56.
  - DONE high only at k+57.
- VALUE=0:
  - LED high over k+1..k+12; BUSY high over k+1..k+28.
  - DONE at k+29; exactly one blink.
- VALUE=15:
  - Exactly 15 LED rising edges; BUSY high for 4×(30+28+4)=248 cycles.
  - DONE follows, with no remaining-count wrap.
- START with VALUE=5 at k+10 during a VALUE=2 sequence:
  - The second START is ignored; 2 blinks only.
  - DONE at k+4×(4+2+4)+1=k+41.
- RST_N=0 at k+20 during VALUE=4:
  - From k+21: LED=0, BUSY=0, no DONE.
  - START=1 with VALUE=1 at the first edge after reset release gives one blink, then DONE.
- Back-to-back: START with VALUE=2 in the DONE cycle of a VALUE=1 sequence gives LED=1 on the next cycle and 2 blinks.
